// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the logic-operation arbiter: opcode and FSM state
// encodings plus a small opcode-legality helper.
package logic_op_pkg;

   localparam int OP_W = 3;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Only the reserved encoding is illegal; every other opcode maps to a gate.
   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      logic legal;
      if (op == OP_RSVD) begin
         legal = 1'b0;
      end else begin
         legal = 1'b1;
      end
      return legal;
   endfunction

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between client blocks and the logic-op arbiter.
// Requester fields are packed side by side: requester i owns op bits
// [3i+2:3i] and operand bits [WIDTH*i +: WIDTH].
interface logic_op_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = $clog2(N_REQ)
);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [3*N_REQ-1:0]     req_op;
   logic [WIDTH*N_REQ-1:0] req_a;
   logic [WIDTH*N_REQ-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [WIDTH-1:0]       rsp_y;
   logic                   rsp_err;

   // Client side: issues requests, consumes responses.
   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
   );

   // Arbiter side: accepts requests, produces responses.
   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
   );

endinterface

// File: rtl/logic_op_arbiter_unit.sv
// Shared combinational gate datapath. Every operation is bitwise over WIDTH
// bits; the reserved opcode yields zero and raises err. Operand b is
// don't-care for NOT.
module logic_op_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             err
);

   // Select the gate function for the presented opcode.
   always_comb begin
      y   = {WIDTH{1'b0}};
      err = ~op_is_legal(op);
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOT:  y = ~a;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_RSVD: y = {WIDTH{1'b0}};
         default: y = {WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin front end for the shared logic-op datapath. One request is
// accepted per IDLE cycle, executed in EXEC and held in RESP until the
// consumer takes it; the round-robin pointer advances past the owner only
// once its response has been delivered.
module logic_op_arbiter
   import logic_op_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   logic_op_arbiter_if.slave  bus
);

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   state_e           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  g_q, g_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
   logic             rsp_err_q, rsp_err_d;

   logic             pick_found_s;
   logic [ID_W-1:0]  pick_idx_s;
   logic [N_REQ-1:0] req_ready_s;
   logic [WIDTH-1:0] unit_y_s;
   logic             unit_err_s;

   // First valid requester at or above ptr, wrapping modulo N_REQ. The loop
   // runs from the farthest offset down so the nearest one is written last.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [ID_W-1:0]  ptr);
      logic            found;
      logic [ID_W-1:0] idx;
      int              pos;
      found = 1'b0;
      idx   = {ID_W{1'b0}};
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = (int'(ptr) + k) % N_REQ;
         if (valid[pos]) begin
            found = 1'b1;
            idx   = ID_W'(pos);
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   logic_op_unit #(.WIDTH(WIDTH)) u_unit (
      .op  (op_q),
      .a   (a_q),
      .b   (b_q),
      .y   (unit_y_s),
      .err (unit_err_s)
   );

   // Round-robin search over the live request vector.
   always_comb begin
      {pick_found_s, pick_idx_s} = rr_pick(bus.req_valid, rr_ptr_q);
   end

   // Grant strobe: one-hot only in IDLE with a valid request, and held low
   // while reset is asserted so no handshake can complete during reset.
   always_comb begin
      req_ready_s = {N_REQ{1'b0}};
      if (!rst && (state_q == ST_IDLE) && pick_found_s) begin
         req_ready_s[pick_idx_s] = 1'b1;
      end else begin
         req_ready_s = {N_REQ{1'b0}};
      end
   end

   // Next-state and next-output computation for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      g_d         = g_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found_s) begin
               g_d     = pick_idx_s;
               op_d    = bus.req_op[OP_W*int'(pick_idx_s) +: OP_W];
               a_d     = bus.req_a[WIDTH*int'(pick_idx_s) +: WIDTH];
               b_d     = bus.req_b[WIDTH*int'(pick_idx_s) +: WIDTH];
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_y_d     = unit_y_s;
            rsp_err_d   = unit_err_s;
            rsp_id_d    = g_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (g_q == LAST_ID) begin
                  rr_ptr_d = {ID_W{1'b0}};
               end else begin
                  rr_ptr_d = g_q + ID_W'(1);
               end
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State, captured request and registered response; reset drops any
   // in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= {ID_W{1'b0}};
         g_q         <= {ID_W{1'b0}};
         op_q        <= {OP_W{1'b0}};
         a_q         <= {WIDTH{1'b0}};
         b_q         <= {WIDTH{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= {ID_W{1'b0}};
         rsp_y_q     <= {WIDTH{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         g_q         <= g_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter with four 8-bit requesters. Inputs are driven
// just after the falling edge and outputs sampled 1 time unit later, away
// from the rising edge. Expected values come from a transaction-level model:
// a gate function, a round-robin pick from a pointer, and a three-phase
// request/execute/respond sequence.
module tb_logic_op_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   vec_cnt;
   int   err_cnt;
   int   model_ptr;

   logic [2:0] rq_op [N];
   logic [7:0] rq_a  [N];
   logic [7:0] rq_b  [N];

   logic_op_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

   logic_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Client obligation: a raised request stays raised until it is accepted.
   for (genvar gi = 0; gi < N; gi++) begin : g_hs
      assert property (@(posedge clk) disable iff (rst)
         (bus.req_valid[gi] && !bus.req_ready[gi]) |=> bus.req_valid[gi])
         else $error("request %0d withdrawn before acceptance", gi);
   end

   function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~a;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return a ^ b;
         3'd6:    return ~(a ^ b);
         default: return 8'h00;
      endcase
   endfunction

   function automatic int ref_grant(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int g);
      logic [N-1:0] one;
      one = 4'b0001;
      if (g < 0) return 4'b0000;
      return one << g;
   endfunction

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      rq_op[i] = op;
      rq_a[i]  = a;
      rq_b[i]  = b;
      bus.req_op[3*i +: 3] = op;
      bus.req_a[8*i +: 8]  = a;
      bus.req_b[8*i +: 8]  = b;
      bus.req_valid[i]     = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      #1;
      vec_cnt++; if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
      vec_cnt++; if (bus.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      vec_cnt++; if (bus.rsp_id !== 2'd0) begin err_cnt++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
      vec_cnt++; if (bus.rsp_y !== 8'h00) begin err_cnt++; $display("FAIL reset_rsp_y got %h want 00", bus.rsp_y); end
      vec_cnt++; if (bus.rsp_err !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
      @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
      @(negedge clk);
      #1;
      vec_cnt++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_quiet got ready=%b valid=%b want 0000/0", bus.req_ready, bus.rsp_valid); end
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      set_req(1, 3'd5, 8'hF0, 8'h3C);
      #1;
      vec_cnt++; if (bus.req_ready !== onehot(ref_grant(bus.req_valid, model_ptr))) begin err_cnt++; $display("FAIL single_grant got %b want %b", bus.req_ready, onehot(ref_grant(bus.req_valid, model_ptr))); end
      @(negedge clk);
      bus.req_valid[1] = 1'b0;
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL single_exec got valid=%b ready=%b want 0/0000", bus.rsp_valid, bus.req_ready); end
      @(negedge clk);
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid got %b want 1", bus.rsp_valid); end
      vec_cnt++; if (bus.rsp_id !== 2'd1) begin err_cnt++; $display("FAIL single_id got %0d want 1", bus.rsp_id); end
      vec_cnt++; if (bus.rsp_y !== 8'hCC || bus.rsp_err !== 1'b0) begin err_cnt++; $display("FAIL single_y got %h/%b want cc/0", bus.rsp_y, bus.rsp_err); end
      model_ptr = 2;
      @(negedge clk);
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL single_drop got %b want 0", bus.rsp_valid); end
   endtask

   task automatic test_all_ops();
      logic [7:0] tbl [8];
      logic [2:0] op;
      tbl = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
      do_reset();
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         op = k[2:0];
         @(negedge clk);
         set_req(0, op, 8'hA5, 8'h0F);
         #1;
         vec_cnt++; if (bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL ops_grant op=%0d got %b want 0001", k, bus.req_ready); end
         @(negedge clk);
         bus.req_valid[0] = 1'b0;
         @(negedge clk);
         #1;
         vec_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== tbl[k] || bus.rsp_err !== (k == 7)) begin
            err_cnt++; $display("FAIL ops_result op=%0d got v=%b y=%h e=%b want 1/%h/%b", k, bus.rsp_valid, bus.rsp_y, bus.rsp_err, tbl[k], (k == 7));
         end
      end
   endtask

   task automatic test_round_robin();
      int order [5];
      int grants;
      int last_cyc;
      int exp_ids [$];
      int id;
      order = '{0, 1, 2, 3, 0};
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
      grants = 0;
      last_cyc = 0;
      for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
         #1;
         if (bus.rsp_valid === 1'b1) begin
            vec_cnt++;
            if (exp_ids.size() == 0) begin
               err_cnt++; $display("FAIL rr_unexpected_rsp got id=%0d want none", bus.rsp_id);
            end else begin
               id = exp_ids.pop_front();
               if (bus.rsp_id !== 2'(id) || bus.rsp_y !== ref_y(rq_op[id], rq_a[id], rq_b[id])) begin
                  err_cnt++; $display("FAIL rr_rsp got id=%0d y=%h want %0d/%h", bus.rsp_id, bus.rsp_y, id, ref_y(rq_op[id], rq_a[id], rq_b[id]));
               end
            end
         end
         if (bus.req_ready !== 4'b0000) begin
            vec_cnt++; if (bus.req_ready !== onehot(order[grants])) begin err_cnt++; $display("FAIL rr_order grant#%0d got %b want %b", grants, bus.req_ready, onehot(order[grants])); end
            if (grants > 0) begin
               vec_cnt++; if (cyc - last_cyc != 3) begin err_cnt++; $display("FAIL rr_interval got %0d want 3", cyc - last_cyc); end
            end
            exp_ids.push_back(order[grants]);
            last_cyc = cyc;
            grants++;
         end
         @(negedge clk);
      end
      vec_cnt++; if (grants != 5) begin err_cnt++; $display("FAIL rr_timeout got %0d grants want 5", grants); end
   endtask

   task automatic test_backpressure();
      logic [2:0] op;
      logic [2:0] op2;
      logic [7:0] hy;
      do_reset();
      op  = 3'($urandom_range(0, 7));
      op2 = 3'($urandom_range(0, 7));
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      set_req(2, op, 8'($urandom), 8'($urandom));
      #1;
      vec_cnt++; if (bus.req_ready !== 4'b0100) begin err_cnt++; $display("FAIL bp_grant got %b want 0100", bus.req_ready); end
      hy = ref_y(op, rq_a[2], rq_b[2]);
      @(negedge clk);
      bus.req_valid[2] = 1'b0;
      set_req(0, op2, 8'($urandom), 8'($urandom));
      #1;
      vec_cnt++; if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_exec_ready got %b want 0000", bus.req_ready); end
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         #1;
         vec_cnt++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_y !== hy || bus.rsp_err !== (op == 3'd7) || bus.req_ready !== 4'b0000) begin
            err_cnt++; $display("FAIL bp_hold cycle %0d got v=%b id=%0d y=%h e=%b rdy=%b want 1/2/%h/%b/0000", s, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_err, bus.req_ready, hy, (op == 3'd7));
         end
         if (s == 4) bus.rsp_ready = 1'b1;
      end
      model_ptr = 3;
      @(negedge clk);
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_release got %b want 0", bus.rsp_valid); end
      vec_cnt++; if (bus.req_ready !== onehot(ref_grant(bus.req_valid, model_ptr))) begin err_cnt++; $display("FAIL bp_next_grant got %b want %b", bus.req_ready, onehot(ref_grant(bus.req_valid, model_ptr))); end
      @(negedge clk);
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_y !== ref_y(op2, rq_a[0], rq_b[0])) begin
         err_cnt++; $display("FAIL bp_second got v=%b id=%0d y=%h want 1/0/%h", bus.rsp_valid, bus.rsp_id, bus.rsp_y, ref_y(op2, rq_a[0], rq_b[0]));
      end
      model_ptr = 1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      set_req(2, 3'd1, 8'h81, 8'($urandom));
      #1;
      vec_cnt++; if (bus.req_ready !== 4'b0100) begin err_cnt++; $display("FAIL rm_first_grant got %b want 0100", bus.req_ready); end
      @(negedge clk);
      bus.req_valid[2] = 1'b0;
      @(negedge clk);
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_y !== (8'h81 | rq_b[2])) begin
         err_cnt++; $display("FAIL rm_first_rsp got v=%b id=%0d y=%h want 1/2/%h", bus.rsp_valid, bus.rsp_id, bus.rsp_y, 8'h81 | rq_b[2]);
      end
      model_ptr = 3;
      @(negedge clk);
      set_req(1, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
      #1;
      vec_cnt++; if (bus.req_ready !== onehot(ref_grant(bus.req_valid, model_ptr))) begin err_cnt++; $display("FAIL rm_second_grant got %b want %b", bus.req_ready, onehot(ref_grant(bus.req_valid, model_ptr))); end
      @(negedge clk);
      bus.req_valid[1] = 1'b0;
      rst = 1'b1;
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_y !== 8'h00 || bus.rsp_err !== 1'b0) begin
         err_cnt++; $display("FAIL rm_async_clear got v=%b id=%0d y=%h e=%b want 0/0/00/0", bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_err);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         #1;
         vec_cnt++; if (bus.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rm_no_rsp cycle %0d got %b want 0", s, bus.rsp_valid); end
      end
      @(negedge clk);
      set_req(2, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      set_req(3, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      #1;
      vec_cnt++; if (bus.req_ready !== onehot(ref_grant(bus.req_valid, model_ptr))) begin err_cnt++; $display("FAIL rm_after_grant got %b want %b", bus.req_ready, onehot(ref_grant(bus.req_valid, model_ptr))); end
      @(negedge clk);
      bus.req_valid[2] = 1'b0;
      @(negedge clk);
      #1;
      vec_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_y !== ref_y(rq_op[2], rq_a[2], rq_b[2])) begin
         err_cnt++; $display("FAIL rm_after_rsp got v=%b id=%0d y=%h want 1/2/%h", bus.rsp_valid, bus.rsp_id, bus.rsp_y, ref_y(rq_op[2], rq_a[2], rq_b[2]));
      end
   endtask

   task automatic test_starvation();
      int k;
      int g;
      int ntx;
      logic got3;
      do_reset();
      bus.rsp_ready = 1'b1;
      k = $urandom_range(0, 2);
      @(negedge clk);
      set_req(k, 3'd0, 8'($urandom), 8'($urandom));
      @(negedge clk);
      bus.req_valid[k] = 1'b0;
      @(negedge clk);
      model_ptr = k + 1;
      ntx = 0;
      got3 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      for (int cyc = 0; cyc < 30 && !got3; cyc++) begin
         #1;
         if (bus.req_ready !== 4'b0000) begin
            g = ref_grant(bus.req_valid, model_ptr);
            vec_cnt++; if (bus.req_ready !== onehot(g)) begin err_cnt++; $display("FAIL starve_grant got %b want %b", bus.req_ready, onehot(g)); end
            ntx++;
            if (bus.req_ready[3] === 1'b1) got3 = 1'b1;
            model_ptr = (g + 1) % N;
         end
         @(negedge clk);
         if (got3) bus.req_valid[3] = 1'b0;
      end
      vec_cnt++; if (!got3 || ntx > N) begin err_cnt++; $display("FAIL starve_bound got granted=%b after %0d transactions want 1 within %0d", got3, ntx, N); end
   endtask

   task automatic test_random();
      int phase;
      int g;
      int exp_id;
      logic [7:0] exp_y;
      logic exp_err;
      logic [N-1:0] last_ready;
      do_reset();
      phase = 0;
      exp_id = 0;
      exp_y = 8'h00;
      exp_err = 1'b0;
      last_ready = 4'b0000;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (last_ready[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         end
         bus.rsp_ready = ($urandom_range(0, 9) < 7);
         #1;
         g = (phase == 0) ? ref_grant(bus.req_valid, model_ptr) : -1;
         vec_cnt++; if (bus.req_ready !== onehot(g)) begin err_cnt++; $display("FAIL rand_ready cycle %0d got %b want %b", cyc, bus.req_ready, onehot(g)); end
         vec_cnt++; if (bus.rsp_valid !== (phase == 2)) begin err_cnt++; $display("FAIL rand_valid cycle %0d got %b want %b", cyc, bus.rsp_valid, (phase == 2)); end
         if (phase == 2) begin
            vec_cnt++;
            if (bus.rsp_id !== 2'(exp_id) || bus.rsp_y !== exp_y || bus.rsp_err !== exp_err) begin
               err_cnt++; $display("FAIL rand_rsp cycle %0d got id=%0d y=%h e=%b want %0d/%h/%b", cyc, bus.rsp_id, bus.rsp_y, bus.rsp_err, exp_id, exp_y, exp_err);
            end
         end
         last_ready = bus.req_ready;
         case (phase)
            0: if (g >= 0) begin
                  exp_id  = g;
                  exp_y   = ref_y(rq_op[g], rq_a[g], rq_b[g]);
                  exp_err = (rq_op[g] == 3'd7);
                  phase   = 1;
               end
            1: phase = 2;
            default: if (bus.rsp_ready) begin
                  model_ptr = (exp_id + 1) % N;
                  phase = 0;
               end
         endcase
      end
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      model_ptr = 0;
      rst = 1'b1;
      bus.req_valid = 4'b0000;
      bus.req_op = 12'h000;
      bus.req_a = 32'h0;
      bus.req_b = 32'h0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_all_ops();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_starvation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
